// File: rtl/shift_add_mul_pkg.sv
// ---------------------------------------------------------------------------
// shift_add_mul_pkg
// Shared definitions for the sequential shift-add multiplier:
//   - operand / result widths
//   - iteration counter width, derived from the operand width
//   - control FSM state encoding
// Related build macro: MUL_EARLY_EXIT_EN (used in shift_add_mul.sv).
// ---------------------------------------------------------------------------
package shift_add_mul_pkg;

    localparam int MUL_OP_W  = 8;
    localparam int MUL_RES_W = 16;
    localparam int MUL_CTR_W = $clog2(MUL_OP_W);

    typedef enum logic {
        IDLE = 1'b0,
        WORK = 1'b1
    } mul_state_e;

endpackage

// File: rtl/shift_add_mul_if.sv
// ---------------------------------------------------------------------------
// shift_add_mul_if
// Start/busy multiply handshake between an initiator (master) and the
// multiplier (slave).
//   a_bi, b_bi : operands, sampled only when a start is accepted
//   start_i    : request, accepted on a rising edge while the slave is idle
//   busy_o     : high while a multiplication is in progress
//   y_bo       : registered product of the last completed multiplication
//   state_o    : debug view of the slave's control FSM
//
// Handshake: start_i is a level sampled on each rising edge; it is accepted
// only when busy_o is low at that edge and ignored (not queued) otherwise.
// busy_o rises after the accepting edge and falls on the edge that loads
// y_bo, so busy_o=0 always means y_bo holds a complete product.
// ---------------------------------------------------------------------------
interface shift_add_mul_if;
    import shift_add_mul_pkg::*;

    logic [MUL_OP_W-1:0]  a_bi;
    logic [MUL_OP_W-1:0]  b_bi;
    logic                 start_i;
    logic                 busy_o;
    logic [MUL_RES_W-1:0] y_bo;
    mul_state_e           state_o;

    modport master (
        output a_bi,
        output b_bi,
        output start_i,
        input  busy_o,
        input  y_bo,
        input  state_o
    );

    modport slave (
        input  a_bi,
        input  b_bi,
        input  start_i,
        output busy_o,
        output y_bo,
        output state_o
    );

endinterface

// File: rtl/shift_add_mul_pp_stage.sv
// ---------------------------------------------------------------------------
// mul_pp_stage
// Combinational partial-product stage: adds the multiplicand, shifted left by
// the current bit position, to the accumulator when the current multiplier
// bit is set.
//   acc_i      : current accumulator
//   a_i        : multiplicand
//   ctr_i      : bit position of the current multiplier bit
//   b_lsb_i    : current multiplier bit
//   acc_next_o : accumulator after this step
// The 16-bit sum cannot overflow since 255*255 < 2^16.
// ---------------------------------------------------------------------------
module mul_pp_stage
    import shift_add_mul_pkg::*;
(
    input  logic [MUL_RES_W-1:0] acc_i,
    input  logic [MUL_OP_W-1:0]  a_i,
    input  logic [MUL_CTR_W-1:0] ctr_i,
    input  logic                 b_lsb_i,
    output logic [MUL_RES_W-1:0] acc_next_o
);

    logic [MUL_RES_W-1:0] a_ext;
    logic [MUL_RES_W-1:0] a_shifted;

    // Widen before shifting so the high bits are not lost.
    assign a_ext      = {{(MUL_RES_W-MUL_OP_W){1'b0}}, a_i};
    assign a_shifted  = a_ext << ctr_i;
    assign acc_next_o = b_lsb_i ? (acc_i + a_shifted) : acc_i;

endmodule

// File: rtl/shift_add_mul.sv
// ---------------------------------------------------------------------------
// shift_add_mul
// Sequential 8x8 unsigned shift-add multiplier, responder side of the
// start/busy handshake. One partial product is accumulated per cycle; the
// product is written to y_bo only on the completing edge, so partial sums
// are never visible.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-high reset (abandons any multiplication)
//   bus   : shift_add_mul_if.slave (a_bi, b_bi, start_i, busy_o, y_bo,
//           state_o debug)
// Build macro MUL_EARLY_EXIT_EN: when defined, WORK finishes as soon as the
// remaining multiplier bits are all zero (latency 1..8 cycles); otherwise
// the latency is a fixed 8 cycles.
// ---------------------------------------------------------------------------
module shift_add_mul
    import shift_add_mul_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_i,
    shift_add_mul_if.slave bus
);

    mul_state_e           state_q;
    mul_state_e           state_d;
    logic [MUL_OP_W-1:0]  a_q;
    logic [MUL_OP_W-1:0]  b_q;
    logic [MUL_RES_W-1:0] acc_q;
    logic [MUL_CTR_W-1:0] ctr_q;
    logic [MUL_RES_W-1:0] y_q;
    logic [MUL_RES_W-1:0] acc_next;
    logic                 last_step;

    mul_pp_stage u_pp_stage (
        .acc_i      (acc_q),
        .a_i        (a_q),
        .ctr_i      (ctr_q),
        .b_lsb_i    (b_q[0]),
        .acc_next_o (acc_next)
    );

    // Completion test for the bit currently being processed.
`ifdef MUL_EARLY_EXIT_EN
    // Done once the multiplier left after this shift is zero: no further
    // partial products can contribute.
    assign last_step = (b_q[MUL_OP_W-1:1] == '0) || (ctr_q == '1);
`else
    assign last_step = (ctr_q == '1);
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start_i) state_d = WORK;
            WORK: if (last_step)   state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            ctr_q <= '0;
            y_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        a_q   <= bus.a_bi;
                        b_q   <= bus.b_bi;
                        acc_q <= '0;
                        ctr_q <= '0;
                    end
                end
                WORK: begin
                    acc_q <= acc_next;
                    b_q   <= b_q >> 1;
                    ctr_q <= ctr_q + 1'b1;
                    // Load the final sum, including this cycle's term.
                    if (last_step) y_q <= acc_next;
                end
                default: ;
            endcase
        end
    end

    // All outputs come straight from registers.
    assign bus.busy_o  = (state_q != IDLE);
    assign bus.y_bo    = y_q;
    assign bus.state_o = state_q;

endmodule

// File: tb/tb_shift_add_mul.sv
// ---------------------------------------------------------------------------
// tb_shift_add_mul
// Directed and random checks of shift_add_mul against a reference built from
// plain arithmetic (product = a*b, latency from the multiplier's top set bit
// when MUL_EARLY_EXIT_EN is defined, 8 otherwise). Inputs are driven and
// outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_shift_add_mul;
    import shift_add_mul_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    shift_add_mul_if bus ();

    shift_add_mul dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference latency in busy cycles.
    function automatic int ref_latency(input logic [7:0] b);
        int l;
`ifdef MUL_EARLY_EXIT_EN
        l = 1;
        for (int i = 0; i < 8; i++) if (b[i]) l = i + 1;
`else
        l = 8;
        if (b === 8'hxx) l = 0;
`endif
        return l;
    endfunction

    // ---------------- driver ----------------
    // Called at a falling edge with the block idle. Pulses start for one
    // cycle, optionally re-pulses start with other operands on busy cycle
    // poke_cyc, then counts busy cycles until completion and checks the
    // latency, the product and that y_bo held its old value while busy.
    task automatic run_mul(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input int poke_cyc, input logic [7:0] pa, input logic [7:0] pb);
        int          lat;
        logic [15:0] y_before;
        logic        y_moved;
        logic [15:0] exp_y;
        y_before    = bus.y_bo;
        y_moved     = 1'b0;
        exp_q.push_back(16'(a) * 16'(b));
        bus.a_bi    = a;
        bus.b_bi    = b;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.a_bi    = 8'($urandom_range(0, 255));
        bus.b_bi    = 8'($urandom_range(0, 255));
        lat = 0;
        while (bus.busy_o === 1'b1 && lat < 40) begin
            lat++;
            if (bus.y_bo !== y_before) y_moved = 1'b1;
            bus.start_i = (lat == poke_cyc);
            if (lat == poke_cyc) begin
                bus.a_bi = pa;
                bus.b_bi = pb;
            end
            @(negedge clk);
        end
        bus.start_i = 1'b0;
        exp_y = exp_q.pop_front();
        check({tag, "_latency"}, 32'(lat), 32'(ref_latency(b)));
        check({tag, "_hold_while_busy"}, {31'b0, y_moved}, 32'd0);
        check({tag, "_product"}, {16'b0, bus.y_bo}, {16'b0, exp_y});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        int         lat;

        rst         = 1'b1;
        bus.a_bi    = '0;
        bus.b_bi    = '0;
        bus.start_i = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'b0, bus.busy_o}, 32'd0);
        check("reset_y", {16'b0, bus.y_bo}, 32'd0);
        check("reset_state", {31'b0, bus.state_o}, {31'b0, IDLE});
        rst = 1'b0;
        @(negedge clk);

        // Basic product, then result stays put while idle.
        run_mul("m3x5", 8'd3, 8'd5, 0, 8'd0, 8'd0);
        repeat (3) @(negedge clk);
        check("m3x5_held", {16'b0, bus.y_bo}, 32'd15);

        // Full-scale operands, no truncation.
        run_mul("m255x255", 8'd255, 8'd255, 0, 8'd0, 8'd0);
        check("m255x255_hex", {16'b0, bus.y_bo}, 32'h0000FE01);

        // Zero operands.
        run_mul("m200x0", 8'd200, 8'd0, 0, 8'd0, 8'd0);
        run_mul("m0x77", 8'd0, 8'd77, 0, 8'd0, 8'd0);
        run_mul("m9x128", 8'd9, 8'd128, 0, 8'd0, 8'd0);

        // Start pulse on the 3rd busy cycle is ignored; then a back-to-back
        // start on the first idle cycle is accepted.
        run_mul("m7x9_ign", 8'd7, 8'd9, 3, 8'd1, 8'd1);
        check("m7x9_state_idle", {31'b0, bus.state_o}, {31'b0, IDLE});
        run_mul("m1x1_b2b", 8'd1, 8'd1, 0, 8'd0, 8'd0);

        // Reset between edges on the 4th busy cycle abandons the work.
        bus.a_bi    = 8'd100;
        bus.b_bi    = 8'd100;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        lat = 1;
        while (lat < 4 && bus.busy_o === 1'b1) begin
            @(negedge clk);
            lat++;
        end
        check("rst_mid_reached_4th", {31'b0, bus.busy_o}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_busy", {31'b0, bus.busy_o}, 32'd0);
        check("rst_mid_y", {16'b0, bus.y_bo}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_stays_idle", {31'b0, bus.busy_o}, 32'd0);
        run_mul("m12x11", 8'd12, 8'd11, 0, 8'd0, 8'd0);

        // Random sweep.
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom_range(0, 255));
            case (i % 4)
                0:       rb = 8'($urandom_range(0, 255));
                1:       rb = 8'($urandom_range(0, 15));
                2:       rb = 8'(1) << $urandom_range(0, 7);
                default: rb = 8'($urandom);
            endcase
            run_mul("rand", ra, rb, 0, 8'd0, 8'd0);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shift_add_mul.md
# shift_add_mul

Sequential 8x8 unsigned shift-add multiplier, the responder side of the start/busy multiply handshake used by the root-extraction FSMs. An initiator drives both operands and pulses start. The block raises busy, accumulates one partial product per cycle, then drops busy with the 16-bit product held stable on its output. It replaces any combinational multiplier on that interface, so long multiply paths stay off the datapath.

## Interface
- Parameters: none. Widths are fixed by the shared package: operands 8 bits, product 16 bits.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- a_bi  in  8  multiplicand; sampled only on an accepted start.
- b_bi  in  8  multiplier; sampled only on an accepted start.
- start_i  in  1  request; accepted when high at a rising edge while the block is IDLE.
- busy_o  out  1  high while a multiplication is in progress. Decoded from state (state != IDLE).
- y_bo  out  16  registered product; holds the last completed result.

## Operation
- States: IDLE, WORK.
- IDLE with start_i=1: capture a_bi into a_q and b_bi into b_q. Clear acc (16 bits) and ctr (3 bits). Go to WORK.
- IDLE with start_i=0: hold all registers.
- WORK, each cycle:
  - If b_q[0]=1, acc <= acc + (a_q << ctr). The sum is 16 bits and cannot overflow, because 255*255 < 2^16.
  - b_q <= b_q >> 1.
  - ctr <= ctr + 1.
- WORK completes when ctr == 7 (base build).
  - On the completing cycle, y_bo <= the final acc value, including that cycle's partial product, and the state returns to IDLE.
- start_i in WORK is ignored and not queued. Operand changes during WORK have no effect.
- Product is unsigned.
  - 0 * x = 0.
  - x * 0 = 0.
- y_bo never shows partial sums. It changes only on a completing edge or on reset.
- Reset (at any time, including mid-WORK): the state goes to IDLE and a_q, b_q, acc, ctr and y_bo are cleared to 0. An in-flight multiplication is abandoned.

## Timing
- Reset values: busy_o=0, y_bo=16'h0000.
- Take start_i accepted at edge N.
  - busy_o goes high after edge N.
  - Base build: busy_o stays high for exactly 8 cycles and falls after edge N+8, at which point y_bo is valid.
- Initiator contract:
  - The initiator may deassert start_i one cycle after asserting it.
  - Sampling busy_o two or more cycles after asserting start_i always sees busy_o=1 until the result is ready.
- Back-to-back: start_i high during the first cycle with busy_o=0 is accepted at the next edge. The previous y_bo holds until the new completion.
- No combinational path from inputs to outputs.

## Configuration
- MUL_EARLY_EXIT_EN undefined:
  - Fixed 8-cycle latency, independent of operands.
- MUL_EARLY_EXIT_EN defined:
  - WORK completes on the cycle where the shifted multiplier (b_q >> 1) becomes 0, or when ctr == 7, whichever comes first.
  - Latency = max(1, index of the most significant set bit of b_bi + 1) cycles.
  - b_bi=0 and b_bi=1 both take 1 cycle; b_bi=8'h80 takes 8 cycles.
  - The result is identical to the base build.
  - The initiator contract still holds, because busy_o is high for at least 1 cycle.

## Structure
- Shared package holds:
  - The state enum: IDLE=1'b0, WORK=1'b1.
  - MUL_OP_W=8 and MUL_RES_W=16.
  - The counter width, derived as clog2(MUL_OP_W).
- One sub-module, mul_pp_stage:
  - Combinational.
  - Inputs: acc, a_q, ctr, b_q[0]. Output: next acc.
  - Isolates the shifter/adder so it can be reused by a future 2-bit-per-cycle variant.
- Control FSM, counter and output register stay in shift_add_mul.

## Test plan
- a=3, b=5, one-cycle start -> busy_o high for 8 cycles, then y_bo=15 and held. In the early-exit build, busy_o is high for 3 cycles.
- a=255, b=255 -> y_bo=65025 (16'hFE01) with no truncation.
- a=200, b=0 -> y_bo=0. Base build: 8 busy cycles. MUL_EARLY_EXIT_EN: 1 busy cycle.
- Start a=7, b=9. Pulse start_i again with a=1, b=1 on the 3rd busy cycle -> second start ignored, y_bo=63.
  - Then start a=1, b=1 on the first idle cycle -> accepted, y_bo=1.
- Start a=100, b=100. Assert rst_i on the 4th busy cycle (between edges) -> busy_o=0 and y_bo=0 immediately.
  - After release, a=12, b=11 -> y_bo=132.
- Random-operand sweep against a reference product in both macro settings -> all products match. Busy length is 8, or equals the multiplier-MSB-derived latency when early exit is compiled in.
